dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Multi-cycle data-memory controller directly downstream of the datapath.
- Consumes ALUResult as the address, plus WriteData and the memory-control strobes. Owns a word-addressed on-chip RAM.
- Returns ReadData to the datapath's result mux.
- Drives Stall to freeze the PC register and regfile write until the access completes. Models a RAM with configurable wait states.

Parameters:
- DEPTH, 64: number of 32-bit words in the RAM; valid word index 0..DEPTH-1.
- WAIT_CYCLES, 2: extra busy cycles before the access commits (0..15).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- MemReq  in  1  access request from the controller (load or store instruction).
- MemWrite  in  1  1 = store, 0 = load; sampled with MemReq.
- Addr  in  32  byte address (datapath ALUResult).
- WriteData  in  32  store data (datapath WriteData).
- ReadData  out  32  registered load data to the datapath.
- Stall  out  1  hold PC and suppress RegWrite while high.
- Done  out  1  one-cycle pulse: access (or error) complete.
- AddrErr  out  1  with Done: access rejected.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - BUSY: counting wait cycles; the access commits on the final BUSY edge.
  - DONE: completion cycle, one cycle only.
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - ReadData=0, Done=0, AddrErr=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset wins over every other event.
- IDLE, MemReq=1, valid address:
  - Latch Addr, WriteData and MemWrite; counter<=WAIT_CYCLES; go to BUSY.
  - A valid address is Addr[1:0]==0 and Addr[31:2]<DEPTH.
- IDLE, MemReq=1, invalid address:
  - Go to DONE with AddrErr<=1 and ReadData<=0.
  - No RAM write takes place.
- IDLE, MemReq=0: stay in IDLE.
- BUSY, counter!=0: counter<=counter-1.
- BUSY, counter==0:
  - Store: RAM[addr>>2]<=latched data.
  - Load: ReadData<=RAM[addr>>2].
  - Go to DONE.
- DONE:
  - Done=1; AddrErr holds the latched error value.
  - Always return to IDLE on the next edge. MemReq is ignored in this cycle.
- Stall is combinational: Stall = (state==IDLE && MemReq) || (state==BUSY).
  - Stall is high in the request cycle even for an erroring access.
  - It is low in DONE, so the PC advances at the end of the DONE cycle.
- Latency:
  - Valid access: Done asserts WAIT_CYCLES+2 cycles after the request cycle; Stall is high for WAIT_CYCLES+2 cycles.
  - Error: Done asserts in the cycle after the request; Stall is high for 1 cycle.
- ReadData holds its value until the next completed load or error. Stores do not change it.
- Latched inputs are used for the whole access. Changes on Addr/WriteData/MemWrite during BUSY have no effect.
- Reset during BUSY abandons the access: no RAM write, no Done pulse.
- MemReq held high continuously: exactly one access per IDLE→BUSY→DONE pass. The next access starts in the IDLE cycle after DONE.

Optional Feature:
- Macro DMEM_BYTE_EN defined:
  - Adds input port MemByte (1 bit).
  - Byte store (MemByte=1, MemWrite=1): writes only byte lane Addr[1:0] of the word (lane 0 = bits 7:0). Other lanes are preserved.
  - Byte load: ReadData = zero-extended byte from lane Addr[1:0].
  - The alignment check is skipped for byte accesses; the range check still applies.
- Macro undefined:
  - No MemByte port.
  - All accesses are word accesses; Addr[1:0]!=0 → AddrErr.

Test Plan:
1. DEPTH=64, WAIT_CYCLES=2. Store 0xDEADBEEF to 0x10, then load 0x10.
   - Each access: Stall high in cycles 0-3 and low in cycle 4; Done pulses in cycle 4.
   - The load returns ReadData=0xDEADBEEF in cycle 4.
2. Load from 0x12 (misaligned).
   - Stall high in cycle 0 only; Done=1 and AddrErr=1 in cycle 1; ReadData=0x00000000.
3. Store 0xCAFEF00D to 0x100 (word 64, out of range), then load 0x0 (prewritten 0x12345678).
   - The store gives AddrErr=1.
   - The load returns 0x12345678; no wrap-around write occurred.
4. Word 0x20 holds 0x11111111. Start a store of 0x22222222 to 0x20 and pull reset low in the second BUSY cycle; then load 0x20.
   - Outputs reset to 0 and no Done pulse appears from the abandoned store.
   - The load returns 0x11111111.
5. Hold MemReq=1 with a load from 0x10 for 10 cycles.
   - Done pulses in cycles 4 and 9 (the new access starts in the IDLE cycle 5).
   - Done is never high for two consecutive cycles.
6. DMEM_BYTE_EN defined. Word 0x20=0x11111111; byte store 0xAB to 0x21.
   - A word load of 0x20 returns 0x1111AB11.
   - A byte load of 0x21 returns 0x000000AB with AddrErr=0.

Source files
------------

// File: rtl/dmem_if.sv
// Datapath <-> data-memory controller bus. MemByte exists only when DMEM_BYTE_EN is defined.
interface dmem_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
`ifdef DMEM_BYTE_EN
  logic        MemByte;
`endif
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        AddrErr;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
`ifdef DMEM_BYTE_EN
    output MemByte,
`endif
    input  ReadData, Stall, Done, AddrErr
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
`ifdef DMEM_BYTE_EN
    input  MemByte,
`endif
    output ReadData, Stall, Done, AddrErr
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle word-addressed data RAM controller with configurable wait states.
// Optional byte-lane loads/stores are enabled by defining DMEM_BYTE_EN.
module dmem_ctrl #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          err_q;
  logic [31:0]   rdata;
  logic          addr_ok, accept, reject, commit, stall;
`ifdef DMEM_BYTE_EN
  logic [1:0]    lane_q;
  logic          byte_q;
`endif

  logic [31:0]   mem [DEPTH];

  always_comb begin
    addr_ok = (bus.Addr[31:2] < 30'(DEPTH));
`ifdef DMEM_BYTE_EN
    addr_ok = addr_ok && (bus.MemByte || (bus.Addr[1:0] == 2'b00));
`else
    addr_ok = addr_ok && (bus.Addr[1:0] == 2'b00);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MemReq) begin
          stall = 1'b1;
          if (addr_ok) begin
            accept    = 1'b1;
            state_nxt = BUSY;
          end else begin
            reject    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= 4'd0;
      err_q <= 1'b0;
      rdata <= 32'd0;
    end else begin
      if (accept) begin
        cnt   <= 4'(WAIT_CYCLES);
        err_q <= 1'b0;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (reject) begin
        err_q <= 1'b1;
        rdata <= 32'd0;
      end
      if (commit && !write_q) begin
`ifdef DMEM_BYTE_EN
        if (byte_q) rdata <= {24'd0, mem[idx_q][{lane_q, 3'b000} +: 8]};
        else        rdata <= mem[idx_q];
`else
        rdata <= mem[idx_q];
`endif
      end
    end
  end

  // Request capture: the access uses these copies, never the live bus
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.Addr[AW+1:2];
      wdata_q <= bus.WriteData;
      write_q <= bus.MemWrite;
`ifdef DMEM_BYTE_EN
      lane_q  <= bus.Addr[1:0];
      byte_q  <= bus.MemByte;
`endif
    end
  end

  // RAM is never cleared; an asserted reset cancels a pending commit
  always_ff @(posedge clk) begin
    if (reset && commit && write_q) begin
`ifdef DMEM_BYTE_EN
      if (byte_q) mem[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      else        mem[idx_q] <= wdata_q;
`else
      mem[idx_q] <= wdata_q;
`endif
    end
  end

  assign bus.Stall    = stall;
  assign bus.Done     = (state == DONE);
  assign bus.AddrErr  = (state == DONE) && err_q;
  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of single accesses plus hand-written
// sequences for reset-abort, back-to-back requests and (with DMEM_BYTE_EN) byte lanes.
module tb_dmem_ctrl;
  localparam int DEPTH = 64;
  localparam int WAIT  = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  dmem_if bus ();

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
    string       nm;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One request cycle, then bus inputs are scrambled to prove they were latched
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_rd, input string nm);
    int lat;
    lat = exp_err ? 1 : WAIT + 2;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      bus.MemReq    = (c == 0);
      bus.MemWrite  = (c == 0) ? w : ~w;
      bus.Addr      = (c == 0) ? a : ~a;
      bus.WriteData = (c == 0) ? d : ~d;
      #1;
      chk($sformatf("%s stall c%0d", nm, c), {31'd0, bus.Stall}, {31'd0, c < lat});
      chk($sformatf("%s done c%0d", nm, c), {31'd0, bus.Done}, {31'd0, c == lat});
      if (c == lat) begin
        chk({nm, " adderr"}, {31'd0, bus.AddrErr}, {31'd0, exp_err});
        chk({nm, " rdata"}, bus.ReadData, exp_rd);
      end
    end
    bus.MemReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_done;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, "st_w0"};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_0000, "st_w8"};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "st_w4"};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, "ld_w4"};
    vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'h0000_0000, "ld_misal"};
    vecs[5]  = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, "st_oor"};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_5678, "ld_nowrap"};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h1234_5678, "st_last"};
    vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5, "ld_last"};
    vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000, "ld_oor"};
    vecs[10] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000, "ld_hibit"};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, "ld_w4_again"};

    reset         = 1'b0;
    bus.MemReq    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Addr      = 32'd0;
    bus.WriteData = 32'd0;
`ifdef DMEM_BYTE_EN
    bus.MemByte   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset rdata", bus.ReadData, 32'd0);
    chk("reset done", {31'd0, bus.Done}, 32'd0);
    chk("reset adderr", {31'd0, bus.AddrErr}, 32'd0);
    chk("reset stall", {31'd0, bus.Stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      do_access(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rd, vecs[i].nm);

    // Reset in the second BUSY cycle abandons the store to 0x20
    @(negedge clk);
    bus.MemReq = 1'b1; bus.MemWrite = 1'b1; bus.Addr = 32'h20; bus.WriteData = 32'h2222_2222;
    #1 chk("abort stall c0", {31'd0, bus.Stall}, 32'd1);
    @(negedge clk);
    bus.MemReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("abort stall c2", {31'd0, bus.Stall}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort rdata", bus.ReadData, 32'd0);
    chk("abort stall", {31'd0, bus.Stall}, 32'd0);
    chk("abort adderr", {31'd0, bus.AddrErr}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("abort no done c%0d", c + 3), {31'd0, bus.Done}, 32'd0);
      @(negedge clk);
    end
    do_access(1'b0, 32'h20, 32'd0, 1'b0, 32'h1111_1111, "ld_after_abort");

    // MemReq held high: one access per IDLE->BUSY->DONE pass
    prev_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.MemReq = 1'b1; bus.MemWrite = 1'b0; bus.Addr = 32'h10; bus.WriteData = 32'd0;
      #1;
      chk($sformatf("hold done c%0d", c), {31'd0, bus.Done}, {31'd0, (c == 4) || (c == 9)});
      chk($sformatf("hold stall c%0d", c), {31'd0, bus.Stall}, {31'd0, !((c == 4) || (c == 9))});
      chk($sformatf("hold dbl c%0d", c), {31'd0, bus.Done && prev_done}, 32'd0);
      if (c == 4 || c == 9) chk($sformatf("hold rdata c%0d", c), bus.ReadData, 32'hDEAD_BEEF);
      prev_done = bus.Done;
    end
    @(negedge clk);
    bus.MemReq = 1'b0;
    #1;
    chk("hold end done", {31'd0, bus.Done}, 32'd0);
    chk("hold end stall", {31'd0, bus.Stall}, 32'd0);

`ifdef DMEM_BYTE_EN
    bus.MemByte = 1'b1;
    do_access(1'b1, 32'h21, 32'h0000_00AB, 1'b0, 32'hDEAD_BEEF, "st_byte1");
    bus.MemByte = 1'b0;
    do_access(1'b0, 32'h20, 32'd0, 1'b0, 32'h1111_AB11, "ld_word_after_byte");
    bus.MemByte = 1'b1;
    do_access(1'b0, 32'h21, 32'd0, 1'b0, 32'h0000_00AB, "ld_byte1");
    do_access(1'b0, 32'h101, 32'd0, 1'b1, 32'h0000_0000, "ld_byte_oor");
    bus.MemByte = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
